ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as LED set (0xED) or reset (0xFF). It pairs with the existing negedge-ps2clk keyboard receiver in the UART/keyboard peripheral and is driven from a CPU-visible register write. It drives both PS/2 lines open-drain through active-high pull-low enables, follows the PS/2 request-to-send protocol, and reports whether the device acknowledged the byte.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_edge.sv | 39 +++
 rtl/ps2_host_tx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host transmitter.
//   ps2_state_t   - transmitter FSM states
//   PS2_DATA_BITS - data bits per frame (parity follows the last one)
//   PS2_ACK_EDGE  - device clock falling edge on which the ACK is sampled
//   odd_parity()  - parity bit making the 9-bit {par, data} word odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam int unsigned PS2_DATA_BITS = 8;
    localparam int unsigned PS2_ACK_EDGE  = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchroniser for an asynchronous PS/2 line plus a
// registered falling-edge detector.
//   i_clk   - system clock
//   i_rst_n - asynchronous active-low reset
//   i_pin   - raw line (idle high)
//   o_sync  - synchronised line level
//   o_fe    - one-cycle pulse, three clocks after a falling pin edge
module ps2_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_fe
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fe;

    // Flops reset to the idle-high level so reset release never looks like an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fe   <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fe   <= r_prev & ~r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fe   = r_fe;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter (request-to-send protocol).
//   clk, rst            - system clock, asynchronous active-low reset
//   tx_data, tx_valid   - command byte offered; taken when tx_valid && tx_ready
//   tx_ready            - high only while idle
//   ps2clk, ps2dat      - raw PS/2 lines (asynchronous inputs)
//   ps2clk_oe/ps2dat_oe - registered open-drain pull-low enables
//   busy                - high from accept until back to idle
//   ack_ok, ack_err     - one-cycle result pulses (ACK / NACK or timeout)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2clk,
    input  logic       ps2dat,
    output logic       ps2clk_oe,
    output logic       ps2dat_oe,
    output logic       busy,
    output logic       ack_ok,
    output logic       ack_err
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       PAR_IDX  = 4'(PS2_DATA_BITS);
    // bitcnt value once the stop-bit edge has been seen; the next edge is the ACK edge.
    localparam logic [3:0]       STOP_CNT = 4'(PS2_ACK_EDGE - 2);

    ps2_state_t       r_state, w_state_nxt;
    logic [8:0]       r_frame, w_frame_nxt;
    logic [INH_W-1:0] r_inh, w_inh_nxt;
    logic [TO_W-1:0]  r_to, w_to_nxt;
    logic [3:0]       r_bitcnt, w_bit_nxt;
    logic             r_clk_oe, w_clk_oe_nxt;
    logic             r_dat_oe, w_dat_oe_nxt;
    logic             r_ack_ok, w_ok_nxt;
    logic             r_ack_err, w_err_nxt;
    logic             r_dat_meta, r_dat_sync;
    logic             w_clk_sync, w_clk_fe, w_to_hit;

    ps2_sync_edge u_clk_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_pin   (ps2clk),
        .o_sync  (w_clk_sync),
        .o_fe    (w_clk_fe)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_dat_meta <= ps2dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_inh     <= '0;
            r_to      <= '0;
            r_bitcnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_inh     <= w_inh_nxt;
            r_to      <= w_to_nxt;
            r_bitcnt  <= w_bit_nxt;
            r_clk_oe  <= w_clk_oe_nxt;
            r_dat_oe  <= w_dat_oe_nxt;
            r_ack_ok  <= w_ok_nxt;
            r_ack_err <= w_err_nxt;
        end
    end

    // Outputs are computed one cycle ahead so line enables and result pulses
    // leave flops and change in the same cycle as the state they belong to.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame;
        w_inh_nxt    = r_inh;
        w_to_nxt     = r_to;
        w_bit_nxt    = r_bitcnt;
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_ok_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_to_hit     = (r_to == TO_LAST);

        unique case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_frame_nxt  = {odd_parity(tx_data), tx_data};
                    w_inh_nxt    = '0;
                    w_clk_oe_nxt = 1'b1;
                    w_state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_inh == INH_LAST) begin
                    // Release clock and pull data (start bit) together.
                    w_dat_oe_nxt = 1'b1;
                    w_to_nxt     = '0;
                    w_state_nxt  = RTS;
                end else begin
                    w_inh_nxt    = r_inh + INH_W'(1);
                    w_clk_oe_nxt = 1'b1;
                end
            end
            RTS: begin
                w_to_nxt     = r_to + TO_W'(1);
                w_dat_oe_nxt = 1'b1;
                if (w_to_hit) begin
                    w_dat_oe_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = WAIT_IDLE;
                end else if (w_clk_fe) begin
                    w_bit_nxt    = '0;
                    w_dat_oe_nxt = ~r_frame[0];
                    w_state_nxt  = DATA;
                end
            end
            DATA: begin
                w_to_nxt     = r_to + TO_W'(1);
                w_dat_oe_nxt = ~r_frame[r_bitcnt];
                if (w_to_hit) begin
                    w_dat_oe_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = WAIT_IDLE;
                end else if (w_clk_fe) begin
                    w_bit_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == PAR_IDX) begin
                        // Stop bit: release data and wait for the device ACK.
                        w_dat_oe_nxt = 1'b0;
                        w_state_nxt  = ACK;
                    end else begin
                        w_dat_oe_nxt = ~r_frame[w_bit_nxt];
                    end
                end
            end
            ACK: begin
                w_to_nxt = r_to + TO_W'(1);
                // The ACK sample takes priority over a coincident timeout.
                if (w_clk_fe && (r_bitcnt == STOP_CNT)) begin
                    w_bit_nxt   = r_bitcnt + 4'd1;
                    w_ok_nxt    = ~r_dat_sync;
                    w_err_nxt   = r_dat_sync;
                    w_state_nxt = WAIT_IDLE;
                end else if (w_to_hit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_sync && r_dat_sync) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign tx_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign ps2clk_oe = r_clk_oe;
    assign ps2dat_oe = r_dat_oe;
    assign ack_ok    = r_ack_ok;
    assign ack_err   = r_ack_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int unsigned INH = 16;
    localparam int unsigned TMO = 200;
    localparam int unsigned H   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2clk_oe, ps2dat_oe, busy, ack_ok, ack_err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2clk_line, ps2dat_line;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // open-drain wired-AND of host and device
    assign ps2clk_line = ~ps2clk_oe & dev_clk;
    assign ps2dat_line = ~ps2dat_oe & dev_dat;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2clk    (ps2clk_line),
        .ps2dat    (ps2dat_line),
        .ps2clk_oe (ps2clk_oe),
        .ps2dat_oe (ps2dat_oe),
        .busy      (busy),
        .ack_ok    (ack_ok),
        .ack_err   (ack_err)
    );

    // ---------------- observation ----------------
    int unsigned cyc = 0;
    int unsigned inh_run = 0;
    int unsigned last_inh = 0;
    logic        rts_dat = 1'b0;
    int unsigned rts_cyc = 0;
    int unsigned err_cyc = 0;
    logic [1:0]  err_oe = 2'b00;
    logic        err_prev_dat = 1'b0;
    logic        prev_dat_oe = 1'b0;
    int unsigned n_ok = 0;
    int unsigned n_err = 0;
    int unsigned n_acc = 0;
    logic [7:0]  acc_q[$];

    always @(negedge clk) begin
        cyc++;
        if (ps2clk_oe) begin
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            rts_dat  = ps2dat_oe;
            rts_cyc  = cyc;
            inh_run  = 0;
        end
        if (ack_ok) n_ok++;
        if (ack_err) begin
            n_err++;
            err_cyc      = cyc;
            err_oe       = {ps2clk_oe, ps2dat_oe};
            err_prev_dat = prev_dat_oe;
        end
        prev_dat_oe = ps2dat_oe;
    end

    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            n_acc++;
            acc_q.push_back(tx_data);
        end
    end

    // Bits a device should see: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Behavioural keyboard: waits for request-to-send, clocks out 10 bits
    // sampling on the rising edge, then answers on the 11th clock.
    task automatic device_xfer(input int abort_fe, input bit nack,
                               output logic [9:0] bits, output bit req);
        int unsigned w;
        bits = '0;
        req  = 1'b0;
        w    = 0;
        while (!(ps2clk_line && !ps2dat_line) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!(ps2clk_line && !ps2dat_line)) return;
        req = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            bits[i-1] = ps2dat_line;
            if (i == abort_fe) return;
            repeat (H) @(negedge clk);
        end
        dev_dat = nack;
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H) @(negedge clk);
        dev_dat = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] d, input bit nack, input string tag);
        logic [9:0] got, exp;
        bit req;
        int unsigned ok0, err0, w;
        exp  = exp_frame(d);
        ok0  = n_ok;
        err0 = n_err;
        send_byte(d);
        device_xfer(0, nack, got, req);
        w = 0;
        while (!tx_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (!req) begin
            mismatched++;
            $display("FAIL %s rts: request-to-send not seen, required seen", tag);
        end
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s frame: got %b required %b (stop,par,d7..d0)", tag, got, exp);
        end
        compared++;
        if (last_inh != INH) begin
            mismatched++;
            $display("FAIL %s inhibit_len: got %0d required %0d", tag, last_inh, INH);
        end
        compared++;
        if (rts_dat !== 1'b1) begin
            mismatched++;
            $display("FAIL %s rts_start: dat_oe got %b required 1", tag, rts_dat);
        end
        compared++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s idle_return: tx_ready=%b busy=%b required 1/0", tag, tx_ready, busy);
        end
        compared++;
        if ((n_ok - ok0) != (nack ? 0 : 1) || (n_err - err0) != (nack ? 1 : 0)) begin
            mismatched++;
            $display("FAIL %s ack_pulses: ok=%0d err=%0d required %0d/%0d", tag,
                     n_ok - ok0, n_err - err0, nack ? 0 : 1, nack ? 1 : 0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        compared++;
        if ({ps2clk_oe, ps2dat_oe, busy, tx_ready, ack_ok, ack_err} !== 6'b000100) begin
            mismatched++;
            $display("FAIL reset_in: clk_oe,dat_oe,busy,ready,ok,err got %b required 000100",
                     {ps2clk_oe, ps2dat_oe, busy, tx_ready, ack_ok, ack_err});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({ps2clk_oe, ps2dat_oe, busy, tx_ready, ack_ok, ack_err} !== 6'b000100) begin
            mismatched++;
            $display("FAIL reset_out: clk_oe,dat_oe,busy,ready,ok,err got %b required 000100",
                     {ps2clk_oe, ps2dat_oe, busy, tx_ready, ack_ok, ack_err});
        end
    endtask

    task automatic test_basic();
        do_frame(8'hED, 1'b0, "basic_ED");
    endtask

    task automatic test_parity();
        logic [7:0] d;
        do_frame(8'h07, 1'b0, "par_07");
        do_frame(8'hFF, 1'b0, "par_FF");
        do_frame(8'h00, 1'b0, "par_00");
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            do_frame(d, 1'b0, "par_rand");
        end
    endtask

    task automatic test_nack();
        do_frame(8'($urandom_range(0, 255)), 1'b1, "nack");
    endtask

    task automatic test_timeout();
        int unsigned ok0, err0, w;
        ok0  = n_ok;
        err0 = n_err;
        send_byte(8'h3C);
        w = 0;
        while (n_err == err0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (n_err != err0 + 1) begin
            mismatched++;
            $display("FAIL timeout_err: pulses got %0d required 1", n_err - err0);
        end
        compared++;
        if (err_cyc - rts_cyc != TMO) begin
            mismatched++;
            $display("FAIL timeout_cycle: got %0d required %0d", err_cyc - rts_cyc, TMO);
        end
        compared++;
        if (err_oe !== 2'b00 || err_prev_dat !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_lines: oe at err %b (required 00), dat_oe before %b (required 1)",
                     err_oe, err_prev_dat);
        end
        w = 0;
        while (!tx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        compared++;
        if (tx_ready !== 1'b1 || n_ok != ok0) begin
            mismatched++;
            $display("FAIL timeout_idle: tx_ready=%b ok_pulses=%0d required 1/0", tx_ready, n_ok - ok0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got, exp;
        bit req;
        int unsigned ok0, err0;
        exp  = exp_frame(8'hA5);
        ok0  = n_ok;
        err0 = n_err;
        send_byte(8'hA5);
        device_xfer(5, 1'b0, got, req);
        @(negedge clk);
        compared++;
        if (!req || got[4:0] !== exp[4:0]) begin
            mismatched++;
            $display("FAIL rstmid_bits: got %b required %b", got[4:0], exp[4:0]);
        end
        compared++;
        if (ps2dat_oe !== ~exp[4]) begin
            mismatched++;
            $display("FAIL rstmid_pre: dat_oe got %b required %b", ps2dat_oe, ~exp[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({ps2clk_oe, ps2dat_oe, busy, tx_ready} !== 4'b0001) begin
            mismatched++;
            $display("FAIL rstmid_async: clk_oe,dat_oe,busy,ready got %b required 0001",
                     {ps2clk_oe, ps2dat_oe, busy, tx_ready});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        compared++;
        if (n_ok != ok0 || n_err != err0) begin
            mismatched++;
            $display("FAIL rstmid_pulse: ok=%0d err=%0d required 0/0", n_ok - ok0, n_err - err0);
        end
        do_frame(8'h55, 1'b0, "post_reset_55");
    endtask

    task automatic test_back_to_back();
        logic [9:0] got1, got2;
        bit req1, req2;
        int unsigned ok0, acc0, q0, w, ok_at_2nd;
        ok0  = n_ok;
        acc0 = n_acc;
        q0   = acc_q.size();
        @(negedge clk);
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        w = 0;
        while (n_acc == acc0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        tx_data = 8'h34;
        device_xfer(0, 1'b0, got1, req1);
        w = 0;
        while (n_acc < acc0 + 2 && w < 500) begin
            @(negedge clk);
            w++;
        end
        ok_at_2nd = n_ok - ok0;
        tx_valid = 1'b0;
        device_xfer(0, 1'b0, got2, req2);
        w = 0;
        while (!tx_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        compared++;
        if (!req1 || got1 !== exp_frame(8'h12)) begin
            mismatched++;
            $display("FAIL b2b_frame1: got %b required %b", got1, exp_frame(8'h12));
        end
        compared++;
        if (!req2 || got2 !== exp_frame(8'h34)) begin
            mismatched++;
            $display("FAIL b2b_frame2: got %b required %b", got2, exp_frame(8'h34));
        end
        compared++;
        if (n_acc - acc0 != 2) begin
            mismatched++;
            $display("FAIL b2b_accepts: got %0d required 2", n_acc - acc0);
        end
        compared++;
        if (acc_q.size() < q0 + 2 || acc_q[q0] !== 8'h12 || acc_q[q0+1] !== 8'h34) begin
            mismatched++;
            $display("FAIL b2b_order: accepted bytes not 12 then 34 (count %0d)", acc_q.size() - q0);
        end
        compared++;
        if (ok_at_2nd != 1) begin
            mismatched++;
            $display("FAIL b2b_second_after_idle: acks before 2nd accept got %0d required 1", ok_at_2nd);
        end
        compared++;
        if (n_ok - ok0 != 2) begin
            mismatched++;
            $display("FAIL b2b_acks: got %0d required 2", n_ok - ok0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
